// File: rtl/bytebeat_voice_scheduler.sv
// Sample-rate sequencer: divides clk down to the audio tick, polls each enabled voice
// over valid/ready, and emits one selected or averaged 8-bit sample per tick.
module bytebeat_voice_scheduler #(
    parameter int NUM_VOICES = 8,
    parameter int DIV_WIDTH  = 9,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_WIDTH-1:0]          divider,
    input  logic [NUM_VOICES-1:0]         voice_en,
    input  logic                          mix_mode,
    input  logic [$clog2(NUM_VOICES)-1:0] voice_sel,
    input  logic [8*NUM_VOICES-1:0]       voice_pcm,
    input  logic [NUM_VOICES-1:0]         voice_vld,
    output logic [NUM_VOICES-1:0]         voice_rdy,
    output logic [7:0]                    sample_out,
    output logic                          sample_vld,
    output logic                          tick,
    output logic                          timeout_err,
    output logic                          overrun_err,
    input  logic                          clear_err
);

    localparam int SEL_W  = $clog2(NUM_VOICES);
    localparam int ACC_W  = 8 + SEL_W;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, POLL, EMIT} state_t;

    state_t              state;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [SEL_W-1:0]    idx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [ACC_W-1:0]    acc;
    logic [7:0]          hold [NUM_VOICES];

    logic                cur_en;
    logic                cur_vld;
    logic [7:0]          cur_pcm;
    logic                last_voice;
    logic                step_done;
    logic                step_timeout;
    logic [7:0]          contrib;
    logic [ACC_W-1:0]    acc_next;
    logic [7:0]          mix_val;
    logic [7:0]          sel_val;

    assign cur_en     = voice_en[idx];
    assign cur_vld    = voice_vld[idx];
    assign cur_pcm    = voice_pcm[{idx, 3'b000} +: 8];
    assign last_voice = (idx == SEL_W'(NUM_VOICES - 1));

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        voice_rdy    = '0;
        step_done    = 1'b0;
        step_timeout = 1'b0;
        contrib      = '0;
        if (state == POLL) begin
            if (!cur_en) begin
                step_done = 1'b1;
            end else begin
                voice_rdy[idx] = 1'b1;
                if (cur_vld) begin
                    step_done = 1'b1;
                    contrib   = cur_pcm;
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    // A silent voice still contributes the sample it last delivered.
                    step_done    = 1'b1;
                    step_timeout = 1'b1;
                    contrib      = hold[idx];
                end
            end
        end
    end

    assign acc_next = acc + ACC_W'(contrib);
    assign mix_val  = acc_next[ACC_W-1:SEL_W];
    // Selected voice as it stands after the current slot's transfer lands.
    assign sel_val  = (cur_en && cur_vld && voice_sel == idx) ? cur_pcm : hold[voice_sel];

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            tick        <= 1'b0;
            idx         <= '0;
            wait_cnt    <= '0;
            acc         <= '0;
            sample_out  <= '0;
            sample_vld  <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
            // NOTE: the hold array is reset deliberately; a stale sample must never reach the mix.
            for (int i = 0; i < NUM_VOICES; i++) hold[i] <= '0;
        end else begin
            if (div_cnt >= divider) begin
                tick    <= 1'b1;
                div_cnt <= '0;
            end else begin
                tick    <= 1'b0;
                div_cnt <= div_cnt + DIV_WIDTH'(1);
            end

            sample_vld <= 1'b0;

            // Clear first so a same-cycle error event wins.
            if (clear_err) begin
                timeout_err <= 1'b0;
                overrun_err <= 1'b0;
            end
            if (tick && state != IDLE) overrun_err <= 1'b1;
            if (step_timeout) timeout_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (tick) begin
                        state    <= POLL;
                        idx      <= '0;
                        acc      <= '0;
                        wait_cnt <= '0;
                    end
                end
                POLL: begin
                    if (step_done) begin
                        acc      <= acc_next;
                        wait_cnt <= '0;
                        idx      <= idx + SEL_W'(1);
                        if (cur_en && cur_vld) hold[idx] <= cur_pcm;
                        if (last_voice) begin
                            state      <= EMIT;
                            sample_vld <= 1'b1;
                            sample_out <= mix_mode ? mix_val : sel_val;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                EMIT:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bytebeat_voice_scheduler.sv
// Bench for bytebeat_voice_scheduler: table of per-collection vectors scored through an
// expectation queue, plus sequences for overrun, timeout clearing and mid-poll reset.
module tb_bytebeat_voice_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  divider;
    logic [7:0]  voice_en;
    logic        mix_mode;
    logic [2:0]  voice_sel;
    logic [63:0] voice_pcm;
    logic [7:0]  voice_vld;
    logic [7:0]  voice_rdy;
    logic [7:0]  sample_out;
    logic        sample_vld;
    logic        tick;
    logic        timeout_err;
    logic        overrun_err;
    logic        clear_err;

    bytebeat_voice_scheduler #(.NUM_VOICES(8), .DIV_WIDTH(9), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .divider(divider), .voice_en(voice_en),
        .mix_mode(mix_mode), .voice_sel(voice_sel), .voice_pcm(voice_pcm),
        .voice_vld(voice_vld), .voice_rdy(voice_rdy), .sample_out(sample_out),
        .sample_vld(sample_vld), .tick(tick), .timeout_err(timeout_err),
        .overrun_err(overrun_err), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  en;
        logic [63:0] pcm;
        logic [7:0]  vld;
        logic        mix;
        logic [2:0]  sel;
        logic [7:0]  exp_out;
        int          exp_lat;
        logic        exp_terr;
        int          exp_rdy4;
    } vec_t;

    typedef struct {
        logic [7:0] value;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    vec_t vecs[10];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_cyc = 0;
    int prev_strobe = 0;
    int rdy_bad = 0;
    int rdy4_cnt = 0;
    bit busy = 0;
    bit mon_on = 0;
    bit gap_on = 0;
    bit have_prev = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [63:0] ramp();
        logic [63:0] p;
        for (int i = 0; i < 8; i++) p[8*i +: 8] = 8'(16 * i);
        return p;
    endfunction

    function automatic vec_t mk(input logic [7:0] en, input logic [63:0] pcm, input logic [7:0] vld,
                                input logic mix, input logic [2:0] sel, input logic [7:0] exp_out,
                                input int lat, input logic terr, input int rdy4);
        vec_t v;
        v.en = en; v.pcm = pcm; v.vld = vld; v.mix = mix; v.sel = sel;
        v.exp_out = exp_out; v.exp_lat = lat; v.exp_terr = terr; v.exp_rdy4 = rdy4;
        return v;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: a tick seen while idle opens a collection; each strobe pops one expectation.
    always @(negedge clk) begin
        if (!$onehot0(voice_rdy) || ((voice_rdy & ~voice_en) != 8'h00)) rdy_bad++;
        if (voice_rdy[4]) rdy4_cnt++;
        if (mon_on) begin
            if (tick && !busy) begin
                busy = 1'b1;
                tick_cyc = cyc;
            end
            if (sample_vld) begin
                busy = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got sample_out=%0d with no collection expected", sample_out);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_out", int'(sample_out), int'(e.value));
                    check("latency", cyc - tick_cyc, e.lat);
                end
                if (gap_on) begin
                    if (have_prev) check("strobe_gap", cyc - prev_strobe, 12);
                    prev_strobe = cyc;
                    have_prev = 1'b1;
                end
            end
        end
    end

    task automatic wait_empty(input int max_cycles);
        for (int n = 0; n < max_cycles; n++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL strobe_timeout: got %0d pending collections expected 0", exp_q.size());
        exp_q.delete();
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        check("errors_cleared", int'({timeout_err, overrun_err}), 0);
    endtask

    task automatic apply_vec(input vec_t v);
        exp_t x;
        voice_en  = v.en;
        voice_pcm = v.pcm;
        voice_vld = v.vld;
        mix_mode  = v.mix;
        voice_sel = v.sel;
        rdy4_cnt  = 0;
        x.value = v.exp_out;
        x.lat   = v.exp_lat;
        exp_q.push_back(x);
        wait_empty(200);
        check("timeout_err", int'(timeout_err), int'(v.exp_terr));
        check("rdy4_cycles", rdy4_cnt, v.exp_rdy4);
        if (v.exp_terr) pulse_clear();
    endtask

    initial begin
        logic [63:0] p;
        int n;
        bit got;

        // Expected mixes: ramp sums to 448 -> 56; {200,100} -> 300>>3 = 37; eight 255s -> 255.
        vecs[0] = mk(8'hFF, ramp(), 8'hFF, 1'b1, 3'd0, 8'd56, 9, 1'b0, 1);
        vecs[1] = mk(8'hFF, ramp(), 8'hFF, 1'b0, 3'd3, 8'd48, 9, 1'b0, 1);
        vecs[2] = mk(8'hFF, ramp(), 8'hFF, 1'b0, 3'd5, 8'd80, 9, 1'b0, 1);
        p = ramp(); p[7:0] = 8'd200; p[23:16] = 8'd100;
        vecs[3] = mk(8'h05, p, 8'hFF, 1'b1, 3'd0, 8'd37, 9, 1'b0, 0);
        p = ramp(); p[39:32] = 8'd250;
        vecs[4] = mk(8'h05, p, 8'hFF, 1'b0, 3'd4, 8'd64, 9, 1'b0, 0);
        vecs[5] = mk(8'hFF, p, 8'hEF, 1'b0, 3'd4, 8'd64, 23, 1'b1, 15);
        vecs[6] = mk(8'hFF, p, 8'hEF, 1'b1, 3'd0, 8'd56, 23, 1'b1, 15);
        vecs[7] = mk(8'hFF, {8{8'hFF}}, 8'hFF, 1'b1, 3'd0, 8'd255, 9, 1'b0, 1);
        vecs[8] = mk(8'hFF, 64'd0, 8'hFF, 1'b1, 3'd0, 8'd0, 9, 1'b0, 1);
        p = 64'd0; p[63:56] = 8'hAB;
        vecs[9] = mk(8'hFF, p, 8'hFF, 1'b0, 3'd7, 8'hAB, 9, 1'b0, 1);

        reset = 1'b1; divider = 9'd15; voice_en = 8'hFF; mix_mode = 1'b1; voice_sel = 3'd0;
        voice_pcm = ramp(); voice_vld = 8'hFF; clear_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_sample_out", int'(sample_out), 0);
        check("reset_strobe_tick", int'({sample_vld, tick}), 0);
        check("reset_rdy", int'(voice_rdy), 0);
        check("reset_errs", int'({timeout_err, overrun_err}), 0);
        reset = 1'b0;
        mon_on = 1'b1;

        for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

        // Fast divider: ticks land mid-collection, each collection spans three tick periods.
        check("overrun_before", int'(overrun_err), 0);
        voice_en = 8'hFF; voice_vld = 8'hFF; voice_pcm = ramp(); mix_mode = 1'b1;
        have_prev = 1'b0;
        gap_on = 1'b1;
        divider = 9'd3;
        for (int i = 0; i < 6; i++) begin
            e.value = 8'd56;
            e.lat = 9;
            exp_q.push_back(e);
        end
        wait_empty(300);
        mon_on = 1'b0;
        gap_on = 1'b0;
        check("overrun_err", int'(overrun_err), 1);

        // Clean restart, then abort a collection while voice 5 is being polled.
        divider = 9'd15;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = tick;
        end
        check("tick_seen", int'(got), 1);
        repeat (6) @(negedge clk);
        check("rdy_idx5", int'(voice_rdy), 8'h20);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_outputs", int'({sample_out, sample_vld, tick, voice_rdy, timeout_err, overrun_err}), 0);
        reset = 1'b0;
        n = 0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            n++;
            got = tick;
            if (sample_vld) begin
                checks++;
                errors++;
                $display("FAIL stale_strobe: got sample_vld=1 expected 0 after aborted collection");
            end
        end
        check("first_tick_delay", n, 16);

        check("rdy_violations", rdy_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bytebeat_voice_scheduler.md
Name: bytebeat_voice_scheduler

Overview:
- Sample-rate sequencer that sits between the bytebeat voice cores and the PWM audio stage.
- Generates the sample-rate tick from the fast system clock, replacing the free-running divider.
- On each tick, polls every enabled voice over its valid/ready handshake, holds each voice's latest sample, and emits one mixed or selected 8-bit sample with a one-cycle valid strobe.
- Detects voices that miss their deadline and ticks that arrive while a collection is still running.

Parameters:
- NUM_VOICES, 8, number of voice ports; must be a power of two, 2..8.
- DIV_WIDTH, 9, width of the sample-rate divider.
- TIMEOUT, 15, maximum cycles spent waiting on one voice's valid.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- divider  input  DIV_WIDTH  tick period minus one, in clk cycles.
- voice_en  input  NUM_VOICES  per-voice enable.
- mix_mode  input  1  0 = output the voice selected by voice_sel; 1 = average of all voices.
- voice_sel  input  $clog2(NUM_VOICES)  voice index used when mix_mode=0.
- voice_pcm  input  8*NUM_VOICES  voice samples; voice i occupies bits [8i+7:8i].
- voice_vld  input  NUM_VOICES  per-voice sample valid.
- voice_rdy  output  NUM_VOICES  per-voice ready; one-hot or zero.
- sample_out  output  8  registered output sample.
- sample_vld  output  1  one-cycle strobe; sample_out updated on the same cycle.
- tick  output  1  one-cycle sample-rate pulse.
- timeout_err  output  1  sticky: some voice missed TIMEOUT.
- overrun_err  output  1  sticky: a tick arrived outside IDLE.
- clear_err  input  1  clears both sticky flags; reset has priority.

Behaviour:
- Reset (synchronous, active-high):
  - all outputs 0; divider counter 0; hold registers 0; FSM in IDLE.
  - Reset asserted mid-collection aborts the collection; no sample_vld is produced.
- Divider:
  - Counter increments every clk.
  - When counter >= divider: tick=1 and counter returns to 0.
  - divider=0 gives tick every cycle. Lowering divider below the current count forces a tick on the next cycle.
- FSM states: IDLE, POLL, EMIT.
  - IDLE: on tick, go to POLL with idx=0, acc=0, wait=0.
  - POLL, voice idx disabled: one cycle, voice_rdy all 0, idx++.
  - POLL, voice idx enabled: voice_rdy[idx]=1 combinationally from the state.
    - If voice_vld[idx]=1 in that cycle: transfer. hold[idx]<=voice_pcm[idx]; idx++; wait<=0.
    - Else wait++. When wait reaches TIMEOUT with no vld: keep old hold[idx], set timeout_err, idx++.
  - POLL: after idx=NUM_VOICES-1 completes, go to EMIT.
- Accumulation:
  - acc (8+log2 NUM_VOICES bits, unsigned) adds the updated hold value of each enabled voice.
  - Disabled voices contribute 0.
- EMIT (one cycle):
  - sample_out <= mix_mode ? acc >> log2(NUM_VOICES) : hold[voice_sel] (value after this poll).
  - sample_vld=1; next state IDLE.
  - Mix output is always sum/NUM_VOICES, so fewer enabled voices give a quieter output; this is intentional, no saturation needed.
- Latency: tick to sample_vld = NUM_VOICES + total wait cycles + 1.
  - With all voices enabled and vld tied high: 9 cycles for 8 voices.
- sample_out holds its value between strobes.
- Tick while not IDLE: tick is dropped, overrun_err set, the current collection continues unaffected.
- Same-cycle events:
  - clear_err together with a new error event: the flag ends up set (set wins).
  - voice_vld while voice_rdy=0: ignored.
- voice_sel and mix_mode are sampled in EMIT only. voice_en is sampled per voice at its POLL slot.

Test Plan:
- Reset, divider=15, all voices enabled, all vld=1, voice i pcm = 16*i, mix_mode=1 -> tick every 16 cycles; sample_vld 9 cycles after each tick; sample_out = (0+16+…+112)/8 = 56.
- mix_mode=0, voice_sel=3, same stimulus -> sample_out=48. Change voice_sel to 5 between ticks -> next strobe gives 80.
- voice_en=8'b00000101, voices 0 and 2 at pcm 200 and 100 -> mix output (200+100)>>3 = 37. Latency is still 9 cycles; voice_rdy never asserts on disabled voices.
- Voice 4 vld stuck low, TIMEOUT=15 -> rdy[4] high for 15 cycles; timeout_err=1; hold[4] keeps its previous value; strobe arrives 23 cycles after tick. clear_err -> flag returns to 0.
- divider=3 with all 8 voices enabled -> ticks arrive during POLL; overrun_err=1; exactly one sample_vld per completed collection.
- Assert reset during POLL at idx=5 -> all outputs 0 the next cycle; no strobe; after release, the first tick arrives divider+1 cycles later.
